// File: rtl/alu_pkg.sv
// Opcode and FSM encodings for the sequential ALU, shared with the CPU decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SLL  = 4'd0,
        OP_SRA  = 4'd1,
        OP_SRL  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DIV  = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_NOR  = 4'd10,
        OP_SLT  = 4'd11,
        OP_SLTU = 4'd12,
        OP_MULU = 4'd13,
        OP_DIVU = 4'd14,
        OP_RSVD = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_multicycle(opcode_e op);
        return op inside {OP_MUL, OP_DIV, OP_MULU, OP_DIVU};
    endfunction

    function automatic logic is_signed_md(opcode_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between a requester and the sequential ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [3:0]       S;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             CF;
    logic             OF;
    logic             Equal;

    modport master (
        output start, X, Y, S,
        input  busy, done, Result1, Result2, CF, OF, Equal
    );

    modport slave (
        input  start, X, Y, S,
        output busy, done, Result1, Result2, CF, OF, Equal
    );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider on unsigned magnitudes.
// One bit per cycle for WIDTH cycles after start; last flags the final step.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

    logic             run_q, run_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] trial;
    logic             fits;

    assign last = run_q && (cnt_q == LAST_CNT);
    assign hi   = acc_q;
    assign lo   = lo_q;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;

        add_sum = {1'b0, acc_q} + {1'b0, opnd_q};
        shl     = {acc_q, lo_q[WIDTH-1]};
        trial   = shl[WIDTH-1:0] - opnd_q;
        fits    = shl >= {1'b0, opnd_q};

        // lo holds the multiplier (mul) or dividend (div); opnd the other operand
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            is_div_d = is_div;
            acc_d    = '0;
            lo_d     = is_div ? a_mag : b_mag;
            opnd_d   = is_div ? b_mag : a_mag;
        end else if (run_q) begin
            cnt_d = cnt_q + SHW'(1);
            if (last) run_d = 1'b0;
            if (is_div_q) begin
                acc_d = fits ? trial : shl[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], fits};
            end else if (lo_q[0]) begin
                {acc_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
            end else begin
                {acc_d, lo_d} = {1'b0, acc_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
        is_div_q <= is_div_d;
        acc_q    <= acc_d;
        lo_q     <= lo_d;
        opnd_q   <= opnd_d;
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete in one cycle; mul/div run on
// muldiv_iter over magnitudes and get their signs restored in FIX.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    opcode_e          op_q, op_d;
    logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d;
    logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d;
    logic             cf_q, cf_d, of_q, of_d, eq_q, eq_d;
    logic             done_q, done_d, busy_q, busy_d;

    opcode_e          op_in;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] sc_r1;
    logic             sc_cf, sc_of;

    logic [WIDTH-1:0] a_mag, b_mag, md_hi, md_lo;
    logic             md_last;
    logic             sgn;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign op_in  = opcode_e'(bus.S);
    assign accept = bus.start && (state_q == ST_IDLE);
    assign shamt  = bus.Y[SHW-1:0];
    assign a_mag  = (is_signed_md(op_in) && bus.X[WIDTH-1]) ? -bus.X : bus.X;
    assign b_mag  = (is_signed_md(op_in) && bus.Y[WIDTH-1]) ? -bus.Y : bus.Y;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_multicycle(op_in)),
        .is_div ((op_in == OP_DIV) || (op_in == OP_DIVU)),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .last   (md_last),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_comb begin
        add_w = {1'b0, bus.X} + {1'b0, bus.Y};
        sub_w = {1'b0, bus.X} - {1'b0, bus.Y};
        sc_r1 = '0;
        sc_cf = 1'b0;
        sc_of = 1'b0;
        case (op_in)
            OP_SLL:  sc_r1 = bus.X << shamt;
            OP_SRA:  sc_r1 = $unsigned($signed(bus.X) >>> shamt);
            OP_SRL:  sc_r1 = bus.X >> shamt;
            OP_ADD: begin
                sc_r1 = add_w[WIDTH-1:0];
                sc_cf = add_w[WIDTH];
                sc_of = (bus.X[WIDTH-1] == bus.Y[WIDTH-1]) && (add_w[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_SUB: begin
                sc_r1 = sub_w[WIDTH-1:0];
                sc_cf = sub_w[WIDTH];
                sc_of = (bus.X[WIDTH-1] != bus.Y[WIDTH-1]) && (sub_w[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_AND:  sc_r1 = bus.X & bus.Y;
            OP_OR:   sc_r1 = bus.X | bus.Y;
            OP_XOR:  sc_r1 = bus.X ^ bus.Y;
            OP_NOR:  sc_r1 = ~(bus.X | bus.Y);
            OP_SLT:  sc_r1 = {{(WIDTH-1){1'b0}}, $signed(bus.X) < $signed(bus.Y)};
            OP_SLTU: sc_r1 = {{(WIDTH-1){1'b0}}, bus.X < bus.Y};
            default: ;
        endcase
    end

    // Sign restoration of the magnitude results, consumed in FIX
    always_comb begin
        sgn  = is_signed_md(op_q);
        prod = {md_hi, md_lo};
        quo  = md_lo;
        rem  = md_hi;
        if (sgn && (xs_q[WIDTH-1] ^ ys_q[WIDTH-1])) begin
            prod = -prod;
            quo  = -quo;
        end
        if (sgn && xs_q[WIDTH-1]) rem = -rem;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        cf_d    = cf_q;
        of_d    = of_q;
        eq_d    = eq_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = op_in;
                    xs_d = bus.X;
                    ys_d = bus.Y;
                    if (is_multicycle(op_in)) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        r1_d    = sc_r1;
                        r2_d    = '0;
                        cf_d    = sc_cf;
                        of_d    = sc_of;
                        eq_d    = (bus.X == bus.Y);
                    end
                end
            end
            ST_CALC: if (md_last) state_d = ST_FIX;
            ST_FIX: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                eq_d    = (xs_q == ys_q);
                cf_d    = 1'b0;
                of_d    = 1'b0;
                if ((op_q == OP_MUL) || (op_q == OP_MULU)) begin
                    {r2_d, r1_d} = prod;
                end else if (ys_q == '0) begin
                    r1_d = '1;
                    r2_d = xs_q;
                end else begin
                    r1_d = quo;
                    r2_d = rem;
                    of_d = (op_q == OP_DIV) && (xs_q == MIN_VAL) && (ys_q == '1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r1_q    <= '0;
            r2_q    <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            eq_q    <= eq_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
        op_q <= op_d;
        xs_q <= xs_d;
        ys_q <= ys_d;
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.Result1 = r1_q;
    assign bus.Result2 = r2_q;
    assign bus.CF      = cf_q;
    assign bus.OF      = of_q;
    assign bus.Equal   = eq_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq at WIDTH=32 against an arithmetic model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference computed with 64-bit integer arithmetic
    function automatic void model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r1, output logic [31:0] r2,
                                  output logic cf, output logic of, output logic eq, output int lat);
        longint          sx, sy, t;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        r1 = '0; r2 = '0; cf = 1'b0; of = 1'b0;
        eq  = (x == y);
        lat = (s == 4'd3 || s == 4'd4 || s == 4'd13 || s == 4'd14) ? 34 : 1;
        case (s)
            4'd0:  r1 = x << y[4:0];
            4'd1:  begin p = sx >>> y[4:0]; r1 = p[31:0]; end
            4'd2:  r1 = x >> y[4:0];
            4'd3:  begin p = sx * sy; r1 = p[31:0]; r2 = p[63:32]; end
            4'd13: begin p = ux * uy; r1 = p[31:0]; r2 = p[63:32]; end
            4'd4: begin
                if (y == 0) begin r1 = '1; r2 = x; end
                else begin
                    t  = sx / sy; p = t; r1 = p[31:0];
                    of = (t > 64'sd2147483647);
                    t  = sx % sy; p = t; r2 = p[31:0];
                end
            end
            4'd14: begin
                if (y == 0) begin r1 = '1; r2 = x; end
                else begin r1 = x / y; r2 = x % y; end
            end
            4'd5: begin
                t = sx + sy; r1 = x + y;
                cf = (ux + uy) > 64'hFFFF_FFFF;
                of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd6: begin
                t = sx - sy; r1 = x - y;
                cf = (ux < uy);
                of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd7:  r1 = x & y;
            4'd8:  r1 = x | y;
            4'd9:  r1 = x ^ y;
            4'd10: r1 = ~(x | y);
            4'd11: r1 = (sx < sy) ? 32'd1 : 32'd0;
            4'd12: r1 = (ux < uy) ? 32'd1 : 32'd0;
            default: ;
        endcase
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_r1"}, 64'(bus.Result1), 64'd0);
        check({tag, "_r2"}, 64'(bus.Result2), 64'd0);
        check({tag, "_flags"}, 64'({bus.CF, bus.OF, bus.Equal}), 64'd0);
    endtask

    // Called #1 after a clock edge with the DUT idle; returns in the same phase.
    task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] x,
                          input logic [31:0] y, input int pulse_at);
        logic [31:0] e1, e2;
        logic        ecf, eof, eeq, busy_ok;
        int          elat, cyc;
        model(s, x, y, e1, e2, ecf, eof, eeq, elat);
        bus.S = s; bus.X = x; bus.Y = y; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!bus.done && cyc < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (cyc == pulse_at) begin
                bus.start = 1'b1; bus.S = OP_ADD; bus.X = 32'd1; bus.Y = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(elat));
        check({tag, "_busy"}, 64'(busy_ok && bus.busy), 64'd1);
        check({tag, "_r1"}, 64'(bus.Result1), 64'(e1));
        check({tag, "_r2"}, 64'(bus.Result2), 64'(e2));
        check({tag, "_cf"}, 64'(bus.CF), 64'(ecf));
        check({tag, "_of"}, 64'(bus.OF), 64'(eof));
        check({tag, "_eq"}, 64'(bus.Equal), 64'(eeq));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_hold"}, 64'({bus.Result2, bus.Result1}), {e2, e1});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          seen;
        logic [3:0]  rs;
        logic [31:0] rx, ry;

        rst = 1'b1;
        bus.start = 1'b0; bus.X = '0; bus.Y = '0; bus.S = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");

        // start coinciding with reset must be dropped
        bus.start = 1'b1; bus.S = OP_ADD; bus.X = 32'd3; bus.Y = 32'd4;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check_cleared("start_in_rst");

        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
        check("add_ovf_const", 64'({bus.Result1, bus.OF, bus.CF}), 64'({32'h8000_0000, 1'b1, 1'b0}));
        run_op("sub_borrow", OP_SUB, 32'd5, 32'd6, 0);
        check("sub_const", 64'({bus.Result1, bus.CF}), 64'({32'hFFFF_FFFF, 1'b1}));
        run_op("mul_neg", OP_MUL, -32'sd3, 32'd7, 0);
        check("mul_const", 64'({bus.Result2, bus.Result1}), 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", OP_DIV, -32'sd7, 32'd2, 0);
        check("div_const", 64'({bus.Result2, bus.Result1}), 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 0);
        check("divu_zero_const", 64'({bus.Result2, bus.Result1}), 64'h0000_0005_FFFF_FFFF);
        run_op("div_zero", OP_DIV, -32'sd9, 32'd0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_const", 64'({bus.Result1, bus.OF}), 64'({32'h8000_0000, 1'b1}));
        run_op("mulu_repulse", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        check("mulu_const", 64'({bus.Result2, bus.Result1}), 64'hFFFF_FFFE_0000_0001);
        run_op("rsvd", OP_RSVD, 32'h1234, 32'h1234, 0);

        // reset in the middle of a divide
        bus.S = OP_DIVU; bus.X = 32'd100; bus.Y = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("rst_mid_calc");
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        check("rst_no_done", 64'(seen), 64'd0);
        run_op("sra_after_rst", OP_SRA, 32'h8000_0000, 32'd36, 0);
        check("sra_const", 64'(bus.Result1), 64'hF800_0000);

        repeat (80) begin
            rs = 4'($urandom_range(0, 15));
            rx = pick();
            ry = ($urandom_range(0, 7) == 0) ? rx : pick();
            run_op($sformatf("rnd_op%0d", rs), rs, rx, ry, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Localparam SHW = clog2(WIDTH), the shift-amount width.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  request strobe; operands sampled when start=1 and busy=0.
REQ-006 X  in  WIDTH  operand A.
REQ-007 Y  in  WIDTH  operand B; Y[SHW-1:0] is the shift amount for shifts.
REQ-008 S  in  4  opcode: 0 SLL, 1 SRA, 2 SRL, 3 MUL, 4 DIV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT, 12 SLTU, 13 MULU, 14 DIVU, 15 reserved.
REQ-009 busy  out  1  operation in progress; new start ignored.
REQ-010 done  out  1  one-cycle pulse, results valid.
REQ-011 Result1  out  WIDTH  main result / product low / quotient.
REQ-012 Result2  out  WIDTH  product high / remainder; 0 for other ops.
REQ-013 CF, OF, Equal  out  1 each  carry/borrow, signed overflow, X==Y.

Function
REQ-014 FSM states IDLE, CALC, FIX, DONE; IDLE->DONE on accepted start with opcode 0-2, 5-12, 15; IDLE->CALC for 3, 4, 13, 14.
REQ-015 CALC SHALL last exactly WIDTH cycles (one multiplier/quotient bit per cycle), then FIX (one cycle: sign correction), then DONE.
REQ-016 DONE lasts one cycle, asserts done, returns to IDLE; latency start->done: 1 cycle single-cycle ops, WIDTH+2 cycles multicycle ops.
REQ-017 busy=1 in CALC and FIX, and in DONE; start while busy=1 SHALL be ignored, operands not resampled.
REQ-018 Outputs registered; Result1/Result2/flags SHALL hold from done until the next accepted start's done; intermediate values never visible.
REQ-019 ADD/SUB: WIDTH-bit wrap; CF = carry-out (ADD) or borrow X<Y unsigned (SUB); OF = signed overflow; both 0 for all other ops except REQ-022.
REQ-020 SLT/SLTU: Result1 = 1 or 0 (signed/unsigned compare). Shifts: shift X by Y[SHW-1:0]; SRA sign-fills.
REQ-021 MUL/MULU: {Result2,Result1} = full 2*WIDTH signed/unsigned product.
REQ-022 DIV/DIVU: quotient truncates toward zero, remainder takes sign of X; DIV of most-negative by -1 gives Result1=most-negative, Result2=0, OF=1.
REQ-023 Divide by zero (signed or unsigned): Result1 all ones, Result2 = X, OF=0, CF=0, same latency.
REQ-024 Equal = (X==Y) of sampled operands, for every opcode.
REQ-025 Opcode 15: Result1=Result2=0, flags 0, single-cycle.

Reset
REQ-026 rst=1 at any cycle, including mid-CALC, SHALL force IDLE, busy=0, done=0, Result1=Result2=0, CF=OF=Equal=0 at the next edge; in-flight operation discarded.
REQ-027 start sampled in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-028 Package alu_pkg holds opcode constants and FSM state encoding; shared with the CPU decoder.
REQ-029 One sub-module, muldiv_iter: radix-2 shift-add multiplier and restoring divider on magnitudes, WIDTH-parametrised, with start/step counter; alu_seq does sign handling and single-cycle ops.

Verification (WIDTH=32)
REQ-030 ADD X=0x7FFFFFFF Y=1 -> Result1=0x80000000, OF=1, CF=0, done 1 cycle after start; SUB X=5 Y=6 -> 0xFFFFFFFF, CF=1.
REQ-031 MUL X=-3 Y=7 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF, done exactly 34 cycles after start, busy=1 throughout.
REQ-032 DIV X=-7 Y=2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; DIVU X=5 Y=0 -> Result1=0xFFFFFFFF, Result2=5; DIV 0x80000000/-1 -> OF=1.
REQ-033 MULU 0xFFFFFFFF*0xFFFFFFFF with start re-pulsed (ADD 1+1) at cycle 5 -> second start ignored, Result2=0xFFFFFFFE, Result1=1.
REQ-034 rst pulsed at cycle 10 of DIVU -> busy=0, outputs 0 next cycle, no done; subsequent SRA X=0x80000000 Y=36 -> Result1=0xF8000000.
